// File: rtl/axis_seq_checker.sv
// Terminal AXI-Stream consumer: periodic tready stalls, checks data steps by +1, counts beats/errors.
// Latency: tready 1 cycle after en, low 1 of every STALL_PERIOD cycles, flop-driven only; stats visible 1 cycle after accept.
module axis_seq_checker #(
  parameter int AXIS_WIDTH   = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int STALL_PERIOD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  s_axis_tvalid,
  input  logic [AXIS_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic                  locked,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  err_flag,
  output logic [AXIS_WIDTH-1:0] last_data
);

  localparam bit STALL_EN = (STALL_PERIOD > 1);
  localparam int SW       = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [SW-1:0] STALL_LAST = STALL_EN ? SW'(STALL_PERIOD - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    en_q;
  logic [SW-1:0]           stall_cnt;
  logic [AXIS_WIDTH-1:0]   expected;
  logic [AXIS_WIDTH-1:0]   expected_nxt;
  logic [AXIS_WIDTH-1:0]   data_inc;
  logic                    locked_nxt;
  logic                    accept;
  logic                    mismatch;

  assign s_axis_tready = en_q && (!STALL_EN || (stall_cnt != STALL_LAST));
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign data_inc      = s_axis_tdata + AXIS_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      en_q      <= 1'b0;
      stall_cnt <= '0;
    end else begin
      en_q <= en;
      if (!en_q || !STALL_EN || (stall_cnt == STALL_LAST)) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      expected <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nxt;
      expected <= expected_nxt;
      locked   <= locked_nxt;
    end
  end

  // tready can already be high while still in IDLE (en_q just rose), so an
  // accept there is treated as the synchronising beat rather than dropped.
  always_comb begin
    state_nxt    = state;
    expected_nxt = expected;
    locked_nxt   = locked;
    mismatch     = 1'b0;
    case (state)
      IDLE: begin
        locked_nxt = 1'b0;
        if (en_q) begin
          state_nxt = SYNC;
          if (accept) begin
            expected_nxt = data_inc;
            locked_nxt   = 1'b1;
            state_nxt    = CHECK;
          end
        end
      end
      SYNC: begin
        if (!en_q) begin
          state_nxt  = IDLE;
          locked_nxt = 1'b0;
        end else if (accept) begin
          expected_nxt = data_inc;
          locked_nxt   = 1'b1;
          state_nxt    = CHECK;
        end
      end
      CHECK: begin
        if (!en_q) begin
          state_nxt  = IDLE;
          locked_nxt = 1'b0;
        end else if (accept) begin
          mismatch     = (s_axis_tdata != expected);
          expected_nxt = data_inc;
        end
      end
      default: begin
        state_nxt  = IDLE;
        locked_nxt = 1'b0;
      end
    endcase
  end

  // clr has priority over a coincident accept or mismatch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_count <= '0;
      err_count  <= '0;
      err_flag   <= 1'b0;
      last_data  <= '0;
    end else begin
      if (accept) begin
        last_data <= s_axis_tdata;
      end
      if (clr) begin
        beat_count <= '0;
        err_count  <= '0;
        err_flag   <= 1'b0;
      end else begin
        if (accept && !(&beat_count)) begin
          beat_count <= beat_count + CNT_WIDTH'(1);
        end
        if (mismatch) begin
          err_flag <= 1'b1;
          if (!(&err_count)) begin
            err_count <= err_count + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_seq_checker.sv
// Scoreboard bench for axis_seq_checker: directed beats push expected stats, a negedge monitor pops and compares.
module tb_axis_seq_checker;

  logic        clk;
  logic        reset;
  logic        en;
  logic        clr;
  logic        tvalid;
  logic [31:0] tdata;

  logic        tready;
  logic        locked;
  logic [15:0] beat16;
  logic [15:0] err16;
  logic        flag16;
  logic [31:0] last16;

  logic        tready4;
  logic        locked4;
  logic [3:0]  beat4;
  logic [3:0]  err4;
  logic        flag4;
  logic [31:0] last4;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] d;
    logic [15:0] b16;
    logic [15:0] e16;
    logic [3:0]  b4;
    logic [3:0]  e4;
    logic        flag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  exp_t m;
  logic pend = 1'b0;

  axis_seq_checker #(.AXIS_WIDTH(32), .CNT_WIDTH(16), .STALL_PERIOD(4)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .s_axis_tvalid(tvalid), .s_axis_tdata(tdata), .s_axis_tready(tready),
    .locked(locked), .beat_count(beat16), .err_count(err16),
    .err_flag(flag16), .last_data(last16)
  );

  axis_seq_checker #(.AXIS_WIDTH(32), .CNT_WIDTH(4), .STALL_PERIOD(4)) dut4 (
    .clk(clk), .reset(reset), .en(en), .clr(clr),
    .s_axis_tvalid(tvalid), .s_axis_tdata(tdata), .s_axis_tready(tready4),
    .locked(locked4), .beat_count(beat4), .err_count(err4),
    .err_flag(flag4), .last_data(last4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m.d = '0; m.b16 = '0; m.e16 = '0; m.b4 = '0; m.e4 = '0; m.flag = 1'b0;
  endtask

  // Expected post-accept state for one beat (mism and clr given by hand).
  task automatic push(input logic [31:0] d, input bit mism, input bit c);
    m.d = d;
    if (c) begin
      m.b16 = '0; m.e16 = '0; m.b4 = '0; m.e4 = '0; m.flag = 1'b0;
    end else begin
      if (m.b16 != 16'hFFFF) m.b16 = m.b16 + 16'd1;
      if (m.b4 != 4'hF) m.b4 = m.b4 + 4'd1;
      if (mism) begin
        if (m.e16 != 16'hFFFF) m.e16 = m.e16 + 16'd1;
        if (m.e4 != 4'hF) m.e4 = m.e4 + 4'd1;
        m.flag = 1'b1;
      end
    end
    sb.push_back(m);
  endtask

  task automatic beat(input logic [31:0] d, input bit mism, input bit c);
    int k;
    k = 0;
    tvalid = 1'b1;
    tdata  = d;
    clr    = c;
    while (!tready && k < 16) begin
      cyc();
      k++;
    end
    chk("tready_within_bound", tready, 1);
    if (tready) push(d, mism, c);
    cyc();
    tvalid = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    en     = 1'b0;
    tvalid = 1'b0;
    cyc();
    model_reset();
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (pend) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_underflow: accept seen with empty queue at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("sb_last_data", last16, e.d);
        chk("sb_beat_count", beat16, e.b16);
        chk("sb_err_count", err16, e.e16);
        chk("sb_err_flag", flag16, e.flag);
        chk("sb_locked", locked, 1);
        chk("sb_beat_count4", beat4, e.b4);
        chk("sb_err_count4", err4, e.e4);
        chk("sb_err_flag4", flag4, e.flag);
      end
    end
    pend = reset && tvalid && tready;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] val;
    int k;
    model_reset();
    reset  = 1'b0;
    en     = 1'b0;
    clr    = 1'b0;
    tvalid = 1'b1;
    tdata  = 32'h55;

    // Reset with tvalid high
    cyc();
    cyc();
    chk("rst_tready", tready, 0);
    chk("rst_locked", locked, 0);
    chk("rst_beat", beat16, 0);
    chk("rst_err", err16, 0);
    chk("rst_flag", flag16, 0);
    chk("rst_last", last16, 0);

    // Nominal stream: tready pattern 1,1,1,0 and 19 beats in 25 cycles
    reset  = 1'b1;
    tvalid = 1'b0;
    en     = 1'b1;
    cyc();
    val = 32'd1;
    for (int i = 0; i < 25; i++) begin
      tvalid = 1'b1;
      tdata  = val;
      chk("tready_pattern", tready, ((i % 4) != 3) ? 1 : 0);
      if (tready) begin
        push(val, 1'b0, 1'b0);
        val = val + 32'd1;
      end
      cyc();
    end
    tvalid = 1'b0;
    chk("nom_locked", locked, 1);
    chk("nom_beat", beat16, 19);
    chk("nom_err", err16, 0);
    chk("nom_last", last16, 19);

    // Error injection: 1..5 then 9,10,11
    do_reset();
    en = 1'b1;
    cyc();
    for (int i = 1; i <= 5; i++) beat(32'(i), 1'b0, 1'b0);
    beat(32'd9, 1'b1, 1'b0);
    beat(32'd10, 1'b0, 1'b0);
    beat(32'd11, 1'b0, 1'b0);
    chk("err_beat", beat16, 8);
    chk("err_count", err16, 1);
    chk("err_flag", flag16, 1);
    chk("err_last", last16, 11);

    // Disable with a beat on the edge en is first sampled low, then re-enable at 9
    k = 0;
    while (!tready && k < 8) begin
      cyc();
      k++;
    end
    chk("pre_disable_tready", tready, 1);
    en     = 1'b0;
    tvalid = 1'b1;
    tdata  = 32'd12;
    if (tready) push(32'd12, 1'b0, 1'b0);
    cyc();
    tvalid = 1'b0;
    chk("dis_locked_hold", locked, 1);
    chk("dis_beat", beat16, 9);
    cyc();
    chk("dis_locked_fall", locked, 0);
    chk("dis_tready", tready, 0);
    for (int i = 0; i < 4; i++) cyc();
    en = 1'b1;
    cyc();
    beat(32'd9, 1'b0, 1'b0);
    beat(32'd10, 1'b0, 1'b0);
    beat(32'd11, 1'b0, 1'b0);
    chk("reen_locked", locked, 1);
    chk("reen_err", err16, 1);
    chk("reen_beat", beat16, 12);

    // Wrap-around, then clr coinciding with a mismatch
    en = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    en = 1'b1;
    cyc();
    beat(32'hFFFF_FFFE, 1'b0, 1'b0);
    beat(32'hFFFF_FFFF, 1'b0, 1'b0);
    beat(32'h0, 1'b0, 1'b0);
    beat(32'h1, 1'b0, 1'b0);
    chk("wrap_err", err16, 1);
    chk("wrap_beat", beat16, 16);
    chk("wrap_beat4_sat", beat4, 15);
    beat(32'd7, 1'b1, 1'b1);
    chk("clr_beat", beat16, 0);
    chk("clr_err", err16, 0);
    chk("clr_flag", flag16, 0);
    chk("clr_last", last16, 7);
    beat(32'd8, 1'b0, 1'b0);
    chk("post_clr_beat", beat16, 1);
    chk("post_clr_flag", flag16, 0);

    // Saturation of the 4-bit counter, then reset mid-stream
    do_reset();
    en = 1'b1;
    cyc();
    for (int i = 0; i < 20; i++) beat(32'd100 + 32'(i), 1'b0, 1'b0);
    chk("sat_beat4", beat4, 15);
    chk("sat_beat16", beat16, 20);
    tvalid = 1'b1;
    tdata  = 32'd120;
    reset  = 1'b0;
    cyc();
    model_reset();
    chk("mid_rst_tready", tready, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_beat", beat16, 0);
    chk("mid_rst_beat4", beat4, 0);
    chk("mid_rst_err", err16, 0);
    chk("mid_rst_flag", flag16, 0);
    chk("mid_rst_last", last16, 0);
    chk("mid_rst_last4", last4, 0);

    // tvalid while idle: nothing accepted
    reset = 1'b1;
    en    = 1'b0;
    cyc();
    cyc();
    chk("idle_tready", tready, 0);
    chk("idle_beat", beat16, 0);
    tvalid = 1'b0;

    @(negedge clk);
    #1;
    chk("sb_drain", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_seq_checker.md
Name: axis_seq_checker

Overview:
- Terminal AXI-Stream consumer placed directly downstream of axis_pipe, in place of axis_sink.
- Applies a deterministic, periodic backpressure pattern on s_axis_tready.
- Checks that accepted data increments by exactly 1 per beat, and counts beats and sequence errors for the bench to read.
- Re-synchronises on every enable, so each source run may start from a different initial value.

Parameters:
- AXIS_WIDTH, 32, width of s_axis_tdata.
- CNT_WIDTH, 16, width of beat_count and err_count.
- STALL_PERIOD, 4, tready is low 1 cycle in every STALL_PERIOD cycles; 0 or 1 disables stalling (tready held high while enabled).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
- en  input  1  checker enable.
- clr  input  1  synchronous clear of statistics.
- s_axis_tvalid  input  1  stream valid.
- s_axis_tdata  input  AXIS_WIDTH  stream data.
- s_axis_tready  output  1  stream ready.
- locked  output  1  high once the first beat of the current enable window is accepted.
- beat_count  output  CNT_WIDTH  accepted beats, saturating.
- err_count  output  CNT_WIDTH  sequence mismatches, saturating.
- err_flag  output  1  sticky: set on any mismatch.
- last_data  output  AXIS_WIDTH  data of the most recent accepted beat.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE; s_axis_tready=0, locked=0, beat_count=0, err_count=0, err_flag=0, last_data=0.
  - stall_cnt=0, expected=0, en_q=0.
- Registers:
  - en_q <= en.
  - stall_cnt counts 0..STALL_PERIOD-1 and wraps while en_q==1; it is held at 0 while en_q==0.
- Ready:
  - s_axis_tready = en_q && (stall_cnt != STALL_PERIOD-1), derived only from flops.
  - No combinational path from s_axis_tvalid or s_axis_tdata to s_axis_tready.
  - When stalling is disabled, s_axis_tready = en_q.
- Accept: a beat is accepted when s_axis_tvalid && s_axis_tready at a rising edge.
  - On accept: last_data <= tdata; beat_count increments, saturating at all-ones.
- Latency: first tready high is 1 cycle after en is sampled high. Statistics update on the accepting edge and are visible the following cycle.
- State machine:
  - IDLE: locked=0. en_q==1 -> SYNC.
  - SYNC: on the first accept, expected <= tdata+1 and locked <= 1, then -> CHECK. No compare is made on this beat.
  - CHECK: on each accept, compare tdata with expected.
    - Match: expected <= tdata+1.
    - Mismatch: err_count increments (saturating), err_flag <= 1, and expected <= tdata+1. The checker resyncs to the new value and stays in CHECK.
  - From SYNC or CHECK: en_q==0 -> IDLE, and locked <= 0.
- Boundary conditions:
  - Wrap-around: expected is computed modulo 2^AXIS_WIDTH, so all-ones followed by 0 is a match.
  - Disable mid-stream: a beat accepted on the same edge that en is first sampled low (tready still high) is counted and checked normally. Statistics are retained across disable. Re-enable re-enters SYNC, so a new start value is not an error.
  - clr==1: clears beat_count, err_count and err_flag. It does not affect state, locked, expected or last_data. When clr coincides with an accept or a mismatch, clr wins and the counts read 0 next cycle.
  - Saturation: a counter at all-ones holds; err_flag still sets on a mismatch.
  - Reset mid-operation: reset overrides everything else and returns to IDLE with all outputs as at reset.
  - tvalid high while the block is in IDLE: tready is 0 and nothing is accepted.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with tvalid=1 -> tready=0, locked=0, every count and flag 0, last_data=0.
2. Nominal (STALL_PERIOD=4): en=1; source starts at 1 and increments by 1 on every handshake for 25 cycles -> tready pattern 1,1,1,0 repeating; locked=1 after the first beat; beat_count equals the handshake count; err_count=0; last_data equals the last value sent.
3. Error injection: send 1..5 then 9,10,11 -> err_count=1, err_flag=1, no further errors after 9; beat_count=8.
4. Re-enable: drop en for 6 cycles, then en=1 with source restarting at 0x9 -> locked falls then rises again; err_count unchanged; beat_count continues from its prior value.
5. Wrap and clr: send 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 -> no error. Then pulse clr in the same cycle as a mismatching beat -> beat_count=0, err_count=0, err_flag=0.
6. Saturation and reset mid-operation: CNT_WIDTH=4, 20 valid beats -> beat_count=15. Then assert reset=0 mid-stream -> all outputs return to reset values on the next cycle.
